// File: rtl/pushbutton_conditioner_if.sv
// Button bus between the board-facing side and the debounced consumer side.
// The master drives the raw button levels; the conditioner (slave) returns the
// stable levels and the one-cycle press/release event pulses.
interface pushbutton_conditioner_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] raw_buttons;
    logic [WIDTH-1:0] pushbuttons;
    logic [WIDTH-1:0] press_pulse;
    logic [WIDTH-1:0] release_pulse;
    logic             any_event;

    modport master (
        output raw_buttons,
        input  pushbuttons,
        input  press_pulse,
        input  release_pulse,
        input  any_event
    );

    modport slave (
        input  raw_buttons,
        output pushbuttons,
        output press_pulse,
        output release_pulse,
        output any_event
    );
endinterface

// File: rtl/pushbutton_conditioner.sv
// Pushbutton conditioner feeding the uP core's pushbuttons input.
// Raw board buttons are brought into the core clock domain through a two-flop
// synchroniser. Each bit is then debounced independently: the stable level only
// follows the synchronised level after it has differed for DEBOUNCE_CYCLES
// uninterrupted cycles. Press/release pulses are registered so they line up with
// the first cycle the new stable level is visible.
module pushbutton_conditioner #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    pushbutton_conditioner_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] press_q;
    logic [WIDTH-1:0] press_d;
    logic [WIDTH-1:0] release_q;
    logic [WIDTH-1:0] release_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // Per-bit debounce decision: count disagreement, commit on the last count
    always_comb begin
        stable_d  = stable_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i]  = sync2_q[i];
                    press_d[i]   = sync2_q[i];
                    release_d[i] = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    // Synchroniser, debounce counters and registered outputs; reset discards any debounce in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= bus.raw_buttons;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.pushbuttons   = stable_q;
    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;
    assign bus.any_event     = |{press_q, release_q};

endmodule

// File: tb/tb_pushbutton_conditioner.sv
// Testbench for pushbutton_conditioner.
// Two instances share the same stimulus: one with the default debounce length
// and one with DEBOUNCE_CYCLES=2. A reference model, described as "the stable
// level follows s2 once the last D samples of s2 all disagree with it", predicts
// every cycle's outputs into a queue; a monitor pops and compares on the falling edge.
module tb_pushbutton_conditioner;

    localparam int D0 = 4;
    localparam int D1 = 2;

    typedef struct packed {
        logic [3:0] level;
        logic [3:0] press;
        logic [3:0] rel;
        logic       any;
    } exp_t;

    logic       clock = 1'b0;
    logic       resetDrive = 1'b1;
    logic [3:0] rawDrive = 4'b0000;

    int total = 0;
    int bad   = 0;

    exp_t expQ0[$];
    exp_t expQ1[$];

    logic [3:0] mS1[2];
    logic [3:0] mS2[2];
    logic [3:0] mStable[2];
    logic [3:0] mHist[2][16];
    int         mHistLen[2];

    exp_t monExp0;
    exp_t monExp1;

    pushbutton_conditioner_if #(.WIDTH(4)) bus0 ();
    pushbutton_conditioner_if #(.WIDTH(4)) bus1 ();

    assign bus0.raw_buttons = rawDrive;
    assign bus1.raw_buttons = rawDrive;

    pushbutton_conditioner #(
        .WIDTH(4), .DEBOUNCE_CYCLES(D0), .CNT_W(8)
    ) dutDefault (
        .clock (clock),
        .reset (resetDrive),
        .bus   (bus0.slave)
    );

    pushbutton_conditioner #(
        .WIDTH(4), .DEBOUNCE_CYCLES(D1), .CNT_W(8)
    ) dutShort (
        .clock (clock),
        .reset (resetDrive),
        .bus   (bus1.slave)
    );

    // Free-running core clock
    always #5 clock = ~clock;

    // Record one comparison and report it if it disagrees
    task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s got=%b expected=%b at %0t", name, actual, expected, $time);
        end
    endtask

    // Advance the reference model of one channel by one rising edge and queue its prediction
    task automatic modelStep(input int ch, input logic [3:0] raw, input logic rst);
        exp_t       e;
        int         d;
        logic [3:0] newStable;
        bit         allDiffer;
        d = (ch == 0) ? D0 : D1;
        e = '0;
        if (rst) begin
            mS1[ch]      = 4'b0;
            mS2[ch]      = 4'b0;
            mStable[ch]  = 4'b0;
            mHistLen[ch] = 0;
        end else begin
            for (int k = 15; k > 0; k--) mHist[ch][k] = mHist[ch][k-1];
            mHist[ch][0] = mS2[ch];
            if (mHistLen[ch] < 16) mHistLen[ch]++;
            newStable = mStable[ch];
            for (int b = 0; b < 4; b++) begin
                allDiffer = (mHistLen[ch] >= d);
                for (int k = 0; k < d; k++) begin
                    if (k < mHistLen[ch] && mHist[ch][k][b] == mStable[ch][b]) allDiffer = 1'b0;
                end
                if (allDiffer) newStable[b] = mHist[ch][0][b];
            end
            e.level = newStable;
            e.press = newStable & ~mStable[ch];
            e.rel   = ~newStable & mStable[ch];
            e.any   = |(e.press | e.rel);
            mStable[ch] = newStable;
            mS2[ch]     = mS1[ch];
            mS1[ch]     = raw;
        end
        if (ch == 0) expQ0.push_back(e);
        else         expQ1.push_back(e);
    endtask

    // Reference model runs on every rising edge with the same inputs the DUTs saw
    always @(posedge clock) begin
        modelStep(0, rawDrive, resetDrive);
        modelStep(1, rawDrive, resetDrive);
    end

    // Monitor: compare each DUT against its predicted outputs away from the active edge
    always @(negedge clock) begin
        if (expQ0.size() > 0) begin
            monExp0 = expQ0.pop_front();
            checkOutput("d4 pushbuttons", bus0.pushbuttons, monExp0.level);
            checkOutput("d4 press_pulse", bus0.press_pulse, monExp0.press);
            checkOutput("d4 release_pulse", bus0.release_pulse, monExp0.rel);
            checkOutput("d4 any_event", {3'b000, bus0.any_event}, {3'b000, monExp0.any});
            checkOutput("d4 press_and_release", bus0.press_pulse & bus0.release_pulse, 4'b0000);
        end
        if (expQ1.size() > 0) begin
            monExp1 = expQ1.pop_front();
            checkOutput("d2 pushbuttons", bus1.pushbuttons, monExp1.level);
            checkOutput("d2 press_pulse", bus1.press_pulse, monExp1.press);
            checkOutput("d2 release_pulse", bus1.release_pulse, monExp1.rel);
            checkOutput("d2 any_event", {3'b000, bus1.any_event}, {3'b000, monExp1.any});
        end
    end

    // Drive raw buttons and reset at the falling edge and hold them for a number of cycles
    task automatic applyStimulus(input logic [3:0] raw, input logic rst, input int cycles);
        rawDrive   = raw;
        resetDrive = rst;
        repeat (cycles) @(negedge clock);
    endtask

    // Directed scenarios followed by randomized bursts with occasional resets
    initial begin
        int hold;
        @(negedge clock);
        $display("[TB] starting pushbutton_conditioner bench");
        applyStimulus(4'b0000, 1'b1, 2);
        applyStimulus(4'b0101, 1'b0, 12);
        applyStimulus(4'b0100, 1'b0, 3);
        applyStimulus(4'b0101, 1'b0, 10);
        applyStimulus(4'b1101, 1'b0, 1);
        applyStimulus(4'b0101, 1'b0, 1);
        applyStimulus(4'b1101, 1'b0, 1);
        applyStimulus(4'b0101, 1'b0, 1);
        applyStimulus(4'b1101, 1'b0, 12);
        applyStimulus(4'b1111, 1'b0, 12);
        applyStimulus(4'b0000, 1'b0, 12);
        applyStimulus(4'b0010, 1'b0, 4);
        applyStimulus(4'b0010, 1'b1, 1);
        applyStimulus(4'b0010, 1'b0, 12);
        applyStimulus(4'b0011, 1'b0, 3);
        applyStimulus(4'b0010, 1'b0, 8);
        applyStimulus(4'b0011, 1'b0, 4);
        applyStimulus(4'b0010, 1'b0, 12);
        for (int n = 0; n < 150; n++) begin
            hold = int'($urandom_range(1, 7));
            if ($urandom_range(0, 29) == 0) begin
                applyStimulus(4'($urandom), 1'b1, 1);
            end
            applyStimulus(4'($urandom), 1'b0, hold);
        end
        applyStimulus(rawDrive, 1'b0, 12);
        #1;
        total++;
        if (expQ0.size() + expQ1.size() > 1) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain got=%0d expected<=1", expQ0.size() + expQ1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        bad++;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/pushbutton_conditioner.md
Name: pushbutton_conditioner

Overview:
Input-conditioning stage directly upstream of the uP core's 4-bit `pushbuttons` input. It synchronises the raw, asynchronous board buttons into the core clock domain and debounces each bit independently. It presents a stable level vector to the core's input port, plus one-cycle press/release event pulses for interrupt-style or polling use. The core samples `pushbuttons` on its input instructions; this block guarantees the value never glitches.

Parameters:
WIDTH, 4, number of button bits (matches the uP input port width)
DEBOUNCE_CYCLES, 4, consecutive clock cycles a synchronised bit must differ from its stable value before the stable value changes; legal range 2..2^CNT_W-1
CNT_W, 8, width of each per-bit debounce counter

Ports:
clock  input  1  core clock, rising-edge active
reset  input  1  synchronous, active-high reset
raw_buttons  input  WIDTH  asynchronous button levels from the board
pushbuttons  output  WIDTH  debounced stable levels, wired to the uP `pushbuttons` input
press_pulse  output  WIDTH  1-cycle pulse per bit on a debounced 0->1 transition
release_pulse  output  WIDTH  1-cycle pulse per bit on a debounced 1->0 transition
any_event  output  1  OR of all press_pulse and release_pulse bits, same cycle

Behaviour:
- Reset: one clock, synchronous reset, active-high. While `reset`=1 at a rising edge, the following registers clear to 0:
  - sync stage 1 and sync stage 2;
  - all counters;
  - `pushbuttons`, `press_pulse`, `release_pulse` and `any_event`.
  - Reset overrides all other activity, including a debounce in progress; that debounce is discarded.
- Synchroniser: two flops per bit (s1 <= raw_buttons, s2 <= s1). Only s2 is used downstream.
- Per-bit debounce, evaluated every rising edge when `reset`=0:
  - If s2[i] == pushbuttons[i]: cnt[i] <= 0; no pulse.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1:
    - pushbuttons[i] <= s2[i] and cnt[i] <= 0;
    - press_pulse[i] <= s2[i];
    - release_pulse[i] <= ~s2[i].
  - Else: cnt[i] <= cnt[i]+1.
- Pulses are registered and default to 0 each cycle. Each pulse is high for exactly one cycle and coincides with the first cycle the new `pushbuttons` value is visible.
- Latency: a raw change captured into s1 at edge E0 appears on `pushbuttons` after edge E(1+DEBOUNCE_CYCLES), provided raw stays stable. With default 4, that is edge E5, i.e. 5 cycles after capture.
- Glitch rejection: any s2 excursion shorter than DEBOUNCE_CYCLES cycles produces no output change and no pulse. The counter restarts from 0 when the excursion ends.
- Bounce: each return to the stable value clears the counter, so the count must be uninterrupted.
- Bits are fully independent. Simultaneous changes on several bits produce simultaneous pulses. `any_event` is combinational OR of the registered pulses.
- Counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around; CNT_W only has to hold that value.
- `press_pulse[i]` and `release_pulse[i]` are never high in the same cycle.

Test Plan:
- Reset, then raw_buttons=4'b0101 held -> pushbuttons=0101 after E5 from capture. press_pulse=0101 for exactly that one cycle, any_event=1 that cycle, release_pulse=0000 throughout.
- From pushbuttons=0101, raw bit0 drops to 0 for 3 cycles then returns -> pushbuttons stays 0101; no pulses; cnt[0] back to 0.
- Bouncing raw bit3 (toggles 1,0,1,0) then held 1 -> pushbuttons[3] rises exactly DEBOUNCE_CYCLES+1 edges after the last toggle's capture; single press_pulse[3].
- From pushbuttons=1111, raw=0000 on all bits at once -> all four bits fall on the same edge; release_pulse=1111 for one cycle; press_pulse=0000.
- reset asserted one cycle while bit1 counter is at 2 (raw bit1=1) -> all outputs 0 next cycle. Counting restarts after reset, and pushbuttons[1] rises only after a full DEBOUNCE_CYCLES+1 edges post-reset.
- DEBOUNCE_CYCLES=2 override, raw 0->1 on bit2 -> pushbuttons[2] rises at E3 from capture; one press_pulse[2].
